// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package dmem_pkg;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  typedef enum logic {
    PORT_CORE = 1'b0,
    PORT_LOAD = 1'b1
  } port_e;

  typedef enum logic {
    RSP_IDLE   = 1'b0,
    RSP_ACTIVE = 1'b1
  } rsp_state_e;

endpackage

// File: rtl/dmem_starve_ctr.sv
// Saturating count of consecutive cycles the loader port lost arbitration.
module dmem_starve_ctr #(
  parameter int unsigned MAX_WAIT = 4,
  parameter int          CNT_W    = dmem_pkg::CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_limit_o
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit_o = (cnt_q == LIMIT);

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter for a single-ported data memory with one-cycle read
// responses and a bounded-wait guarantee for the loader port.
module dmem_port_arbiter
  import dmem_pkg::*;
#(
  parameter int          ADDR_W   = dmem_pkg::ADDR_W,
  parameter int          DATA_W   = dmem_pkg::DATA_W,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic gnt0;
  logic gnt1;
  logic accept;
  logic at_limit;

  rsp_state_e state_q, state_d;
  port_e      owner_q, owner_d;
  logic       was_read_q, was_read_d;

  // Loader wins when the core is idle or once it has waited MAX_WAIT cycles.
  always_comb begin
    gnt1   = !rst && req1_valid && (!req0_valid || at_limit);
    gnt0   = !rst && req0_valid && !gnt1;
    accept = gnt0 || gnt1;
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  dmem_starve_ctr #(
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (CNT_W)
  ) u_starve (
    .clk        (clk),
    .rst        (rst),
    .inc_i      (req1_valid && gnt0),
    .clr_i      (!req1_valid || gnt1),
    .at_limit_o (at_limit)
  );

  always_comb begin
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt1) begin
      mem_re    = !req1_we;
      mem_we    = req1_we;
      mem_addr  = req1_addr;
      mem_wdata = req1_wdata;
    end else if (gnt0) begin
      mem_re    = !req0_we;
      mem_we    = req0_we;
      mem_addr  = req0_addr;
      mem_wdata = req0_wdata;
    end
  end

  always_comb begin
    state_d    = RSP_IDLE;
    owner_d    = owner_q;
    was_read_d = was_read_q;
    if (accept) begin
      state_d    = RSP_ACTIVE;
      owner_d    = gnt1 ? PORT_LOAD : PORT_CORE;
      was_read_d = gnt1 ? !req1_we : !req0_we;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RSP_IDLE;
      owner_q    <= PORT_CORE;
      was_read_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      was_read_q <= was_read_d;
    end
  end

  always_comb begin
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    rsp0_rdata = '0;
    rsp1_rdata = '0;
    if (state_q == RSP_ACTIVE) begin
      if (owner_q == PORT_LOAD) begin
        rsp1_valid = 1'b1;
        rsp1_rdata = was_read_q ? mem_rdata : '0;
      end else begin
        rsp0_valid = 1'b1;
        rsp0_rdata = was_read_q ? mem_rdata : '0;
      end
    end
  end

endmodule
